// File: rtl/param_register_file.sv
// Parametrised decode-stage register file: two combinational read ports, two prioritised
// write ports, optional same-cycle bypass, per-register busy scoreboard and a debug port.
module param_register_file #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] Read1,
    input  logic [ADDR_W-1:0] Read2,
    output logic [DATA_W-1:0] Data1,
    output logic [DATA_W-1:0] Data2,
    output logic              Busy1,
    output logic              Busy2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg2,
    input  logic [DATA_W-1:0] WriteData2,
    input  logic              RegWrite2,
    input  logic              Reserve,
    input  logic [ADDR_W-1:0] ReserveReg,
    output logic              WriteConflict,
    input  logic [ADDR_W-1:0] regNo,
    output logic [DATA_W-1:0] val
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              wc_q;

    logic wr_a, wr_b, rsv, conflict;

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_busy [2];

    function automatic logic valid_target(input logic [ADDR_W-1:0] a);
        return !(ZERO_REG && (a == '0));
    endfunction

    // Port B is suppressed whenever port A targets the same address, so at most one write per register.
    always_comb begin
        wr_a     = RegWrite && valid_target(WriteReg);
        wr_b     = RegWrite2 && valid_target(WriteReg2) && !(RegWrite && (WriteReg2 == WriteReg));
        rsv      = Reserve && valid_target(ReserveReg);
        conflict = RegWrite && RegWrite2 && (WriteReg == WriteReg2) && valid_target(WriteReg);
    end

    // Reserve is applied last so it wins over a same-edge write clear.
    always_comb begin
        busy_nxt = busy;
        if (wr_a) busy_nxt[WriteReg]   = 1'b0;
        if (wr_b) busy_nxt[WriteReg2]  = 1'b0;
        if (rsv)  busy_nxt[ReserveReg] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
            wc_q <= 1'b0;
        end else begin
            if (wr_a) regs[WriteReg]  <= WriteData;
            if (wr_b) regs[WriteReg2] <= WriteData2;
            busy <= busy_nxt;
            wc_q <= conflict;
        end
    end

    assign rd_addr[0] = Read1;
    assign rd_addr[1] = Read2;

    always_comb begin
        logic hit_a;
        logic hit_b;
        for (int unsigned p = 0; p < 2; p++) begin
            hit_a      = wr_a && (WriteReg == rd_addr[p]);
            hit_b      = wr_b && (WriteReg2 == rd_addr[p]);
            rd_data[p] = regs[rd_addr[p]];
            rd_busy[p] = busy[rd_addr[p]];
            if (BYPASS && rst_n) begin
                if (hit_a)      rd_data[p] = WriteData;
                else if (hit_b) rd_data[p] = WriteData2;
                if ((hit_a || hit_b) && !(rsv && (ReserveReg == rd_addr[p]))) begin
                    rd_busy[p] = 1'b0;
                end
            end
            if (!valid_target(rd_addr[p])) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign Data1         = rd_data[0];
    assign Data2         = rd_data[1];
    assign Busy1         = rd_busy[0];
    assign Busy2         = rd_busy[1];
    assign WriteConflict = wc_q;
    assign val           = valid_target(regNo) ? regs[regNo] : '0;

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: behavioural model checked every cycle on the default
// instance, plus directed literal checks on it and on a narrow no-zero-reg/no-bypass instance.
module tb_param_register_file;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  Read1 = '0, Read2 = '0, WriteReg = '0, WriteReg2 = '0, ReserveReg = '0, regNo = '0;
    logic [31:0] WriteData = '0, WriteData2 = '0;
    logic        RegWrite = 1'b0, RegWrite2 = 1'b0, Reserve = 1'b0;
    logic [31:0] Data1, Data2, val;
    logic        Busy1, Busy2, WriteConflict;

    logic [2:0]  p_rd1 = '0, p_rd2 = '0, p_wr = '0, p_wr2 = '0, p_rr = '0, p_no = '0;
    logic [15:0] p_wd = '0, p_wd2 = '0;
    logic        p_we = 1'b0, p_we2 = 1'b0, p_rsv = 1'b0;
    logic [15:0] p_d1, p_d2, p_val;
    logic        p_b1, p_b2, p_wc;

    int vectors = 0;
    int miscompares = 0;

    param_register_file dut0 (
        .clk(clk), .rst_n(rst_n),
        .Read1(Read1), .Read2(Read2), .Data1(Data1), .Data2(Data2),
        .Busy1(Busy1), .Busy2(Busy2),
        .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
        .WriteReg2(WriteReg2), .WriteData2(WriteData2), .RegWrite2(RegWrite2),
        .Reserve(Reserve), .ReserveReg(ReserveReg),
        .WriteConflict(WriteConflict), .regNo(regNo), .val(val)
    );

    param_register_file #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .Read1(p_rd1), .Read2(p_rd2), .Data1(p_d1), .Data2(p_d2),
        .Busy1(p_b1), .Busy2(p_b2),
        .WriteReg(p_wr), .WriteData(p_wd), .RegWrite(p_we),
        .WriteReg2(p_wr2), .WriteData2(p_wd2), .RegWrite2(p_we2),
        .Reserve(p_rsv), .ReserveReg(p_rr),
        .WriteConflict(p_wc), .regNo(p_no), .val(p_val)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the default instance: register contents, busy bits, conflict flag.
    bit [31:0] m_reg [32];
    bit        m_busy [32];
    bit        m_wc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  <= '0;
                m_busy[i] <= 1'b0;
            end
            m_wc <= 1'b0;
        end else begin
            m_wc <= RegWrite && RegWrite2 && (WriteReg == WriteReg2) && (WriteReg != 0);
            if (RegWrite && WriteReg != 0) begin
                m_reg[WriteReg]  <= WriteData;
                m_busy[WriteReg] <= 1'b0;
            end
            if (RegWrite2 && WriteReg2 != 0 && !(RegWrite && WriteReg == WriteReg2)) begin
                m_reg[WriteReg2]  <= WriteData2;
                m_busy[WriteReg2] <= 1'b0;
            end
            if (Reserve && ReserveReg != 0) m_busy[ReserveReg] <= 1'b1;
        end
    end

    function automatic logic [31:0] e_data(input logic [4:0] a);
        if (!rst_n || a == 0) return 32'h0;
        if (RegWrite && a == WriteReg) return WriteData;
        if (RegWrite2 && a == WriteReg2) return WriteData2;
        return m_reg[a];
    endfunction

    function automatic logic e_busy(input logic [4:0] a);
        if (!rst_n || a == 0) return 1'b0;
        if (((RegWrite && a == WriteReg) || (RegWrite2 && a == WriteReg2)) &&
            !(Reserve && ReserveReg == a)) return 1'b0;
        return m_busy[a];
    endfunction

    always @(negedge clk) begin
        chk("data1", Data1, e_data(Read1));
        chk("data2", Data2, e_data(Read2));
        chk("busy1", {31'h0, Busy1}, {31'h0, e_busy(Read1)});
        chk("busy2", {31'h0, Busy2}, {31'h0, e_busy(Read2)});
        chk("val", val, (rst_n && regNo != 0) ? m_reg[regNo] : 32'h0);
        chk("wconf", {31'h0, WriteConflict}, {31'h0, m_wc});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWrite = 1'b0; RegWrite2 = 1'b0; Reserve = 1'b0;
        p_we = 1'b0; p_we2 = 1'b0; p_rsv = 1'b0;
    endtask

    initial begin
        repeat (2) step();
        chk("rst_data1", Data1, 32'h0);
        chk("rst_val", val, 32'h0);
        chk("rst_wc", {31'h0, WriteConflict}, 32'h0);
        rst_n = 1'b1;

        // Write r1, then asynchronous reset pulse between edges.
        step();
        RegWrite = 1'b1; WriteReg = 5'd1; WriteData = 32'hAAAAAAAA; Read1 = 5'd1; regNo = 5'd1;
        step();
        idle();
        chk("r1_data1", Data1, 32'hAAAAAAAA);
        chk("r1_val", val, 32'hAAAAAAAA);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_data1", Data1, 32'h0);
        chk("arst_val", val, 32'h0);
        chk("arst_wc", {31'h0, WriteConflict}, 32'h0);
        #1 rst_n = 1'b1;

        // Same-cycle bypass on port A.
        step();
        RegWrite = 1'b1; WriteReg = 5'd2; WriteData = 32'h55555555; Read2 = 5'd2; regNo = 5'd2;
        #1;
        chk("byp_data2", Data2, 32'h55555555);
        chk("byp_val_pre", val, 32'h0);
        step();
        idle();
        chk("byp_val_post", val, 32'h55555555);

        // Collision on r3: port A wins, conflict pulses one cycle.
        RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h11111111;
        RegWrite2 = 1'b1; WriteReg2 = 5'd3; WriteData2 = 32'h22222222; Read1 = 5'd3;
        #1;
        chk("col_byp", Data1, 32'h11111111);
        step();
        idle();
        chk("col_r3", Data1, 32'h11111111);
        chk("col_wc1", {31'h0, WriteConflict}, 32'h1);
        step();
        chk("col_wc0", {31'h0, WriteConflict}, 32'h0);

        // Collision on r0 is masked entirely.
        RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h11111111;
        RegWrite2 = 1'b1; WriteReg2 = 5'd0; WriteData2 = 32'h22222222; Read1 = 5'd0;
        #1;
        chk("r0_byp", Data1, 32'h0);
        step();
        idle();
        chk("r0_data", Data1, 32'h0);
        chk("r0_wc", {31'h0, WriteConflict}, 32'h0);

        // Scoreboard reserve then port B write.
        Reserve = 1'b1; ReserveReg = 5'd4;
        step();
        idle();
        Read1 = 5'd4;
        #1;
        chk("sb_busy", {31'h0, Busy1}, 32'h1);
        RegWrite2 = 1'b1; WriteReg2 = 5'd4; WriteData2 = 32'hDEADBEEF;
        #1;
        chk("sb_busy_byp", {31'h0, Busy1}, 32'h0);
        step();
        idle();
        chk("sb_busy_post", {31'h0, Busy1}, 32'h0);
        chk("sb_data_post", Data1, 32'hDEADBEEF);

        // Reserve and write race on r5.
        Reserve = 1'b1; ReserveReg = 5'd5; RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'h5; Read1 = 5'd5;
        step();
        idle();
        chk("race_busy", {31'h0, Busy1}, 32'h1);
        chk("race_data", Data1, 32'h5);

        // Reserve of r0 is ignored.
        Reserve = 1'b1; ReserveReg = 5'd0; Read2 = 5'd0;
        step();
        idle();
        chk("rsv_r0", {31'h0, Busy2}, 32'h0);

        // Mixed traffic checked by the model every cycle.
        for (int i = 1; i < 24; i++) begin
            RegWrite   = (i % 3) != 0;
            WriteReg   = 5'(i);
            WriteData  = 32'h1000_0000 + 32'(i);
            RegWrite2  = (i % 2) == 0;
            WriteReg2  = (i % 4 == 0) ? 5'(i) : 5'(i + 5);
            WriteData2 = 32'h2000_0000 + 32'(i);
            Reserve    = (i % 5) < 2;
            ReserveReg = 5'(i + (i % 2));
            Read1      = 5'(i);
            Read2      = 5'(i + 5);
            regNo      = 5'(i - 1);
            step();
        end
        idle();

        // Narrow instance: no zero register, no bypass.
        p_we = 1'b1; p_wr = 3'd0; p_wd = 16'hBEEF; p_we2 = 1'b1; p_wr2 = 3'd7; p_wd2 = 16'h1234;
        p_rd1 = 3'd0; p_rd2 = 3'd7; p_no = 3'd0;
        #1;
        chk("p_nobyp1", {16'h0, p_d1}, 32'h0);
        chk("p_nobyp2", {16'h0, p_d2}, 32'h0);
        step();
        idle();
        chk("p_r0", {16'h0, p_d1}, 32'h0000BEEF);
        chk("p_r7", {16'h0, p_d2}, 32'h00001234);
        chk("p_val0", {16'h0, p_val}, 32'h0000BEEF);
        chk("p_wc0", {31'h0, p_wc}, 32'h0);
        p_we = 1'b1; p_wr = 3'd0; p_wd = 16'h0A0A; p_we2 = 1'b1; p_wr2 = 3'd0; p_wd2 = 16'h0B0B;
        step();
        idle();
        chk("p_col_r0", {16'h0, p_d1}, 32'h00000A0A);
        chk("p_col_wc", {31'h0, p_wc}, 32'h1);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
